// File: rtl/mul_issue_ctrl_if.sv
// Execute-stage side of the multiply issue controller: MULT/MULTU requests,
// MTHI/MTLO writes, and the architectural HI/LO plus stall/completion flags.
interface mul_issue_ctrl_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, is_signed, a_in, b_in, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, is_signed, a_in, b_in, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/capture controller for a fixed-latency unsigned 32x32 multiplier: feeds it operand
// magnitudes, counts out its latency, then sign-corrects the product into HI/LO.
module mul_issue_ctrl #(
  parameter int unsigned MUL_LATENCY = 33
) (
  input  logic                clk,
  input  logic                reset,
  mul_issue_ctrl_if.slave     cpu,
  output logic                mul_reset,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  input  logic [63:0]         mul_z
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_e;

  localparam logic [5:0] LastCnt = 6'(MUL_LATENCY - 1);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        mul_reset_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] product_fixed;

  // 0x80000000 negates to itself, which the unsigned multiplier reads as 2^31.
  always_comb begin
    a_mag = (cpu.is_signed && cpu.a_in[31]) ? (~cpu.a_in + 32'd1) : cpu.a_in;
    b_mag = (cpu.is_signed && cpu.b_in[31]) ? (~cpu.b_in + 32'd1) : cpu.b_in;
  end

  always_comb begin
    product_fixed = neg_q ? (~mul_z + 64'd1) : mul_z;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_reset_q <= 1'b1;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A same-cycle start still lets the move land; the product overwrites it later.
          if (cpu.mthi) hi_q <= cpu.wdata;
          if (cpu.mtlo) lo_q <= cpu.wdata;
          if (cpu.start) begin
            neg_q       <= cpu.is_signed & (cpu.a_in[31] ^ cpu.b_in[31]);
            mul_a_q     <= a_mag;
            mul_b_q     <= b_mag;
            mul_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          mul_reset_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StRun;
        end
        StRun: begin
          if (cnt_q == LastCnt) begin
            {hi_q, lo_q} <= product_fixed;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            mul_reset_q  <= 1'b1;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu.hi    = hi_q;
  assign cpu.lo    = lo_q;
  assign cpu.busy  = busy_q;
  assign cpu.done  = done_q;
  assign mul_reset = mul_reset_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural fixed-latency multiplier;
// directed operands with hand-computed products.
module tb_mul_issue_ctrl;
  localparam int unsigned LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mul_reset;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;

  mul_issue_ctrl_if bus ();

  mul_issue_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus),
    .mul_reset (mul_reset),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Product is only valid once the multiplier has run LAT cycles out of reset; garbage before.
  always @(posedge clk) begin
    if (mul_reset) mcnt <= 0;
    else           mcnt <= mcnt + 1;
  end

  always_comb begin
    if (mcnt >= int'(LAT) - 1) mul_z = {32'b0, mul_a} * {32'b0, mul_b};
    else                       mul_z = 64'hDEAD_BEEF_0BAD_F00D;
  end

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done) begin
      chk("done_single_cycle", {63'b0, done_prev}, 64'd0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done pulsed at cycle %0d, required none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("product", {bus.hi, bus.lo}, mon_e.prod);
        chk("done_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
    done_prev <= bus.done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge; the expected done lands MUL_LATENCY+1 edges after it.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expp, input bit expect_done);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.a_in      = a;
    bus.b_in      = b;
    if (expect_done) begin
      e.prod = expp;
      e.at   = cyc + int'(LAT) + 2;
      sbq.push_back(e);
    end
    tick();
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 2) chk("mul_reset_run", {63'b0, mul_reset}, 64'd0);
      tick();
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expp);
    int n;
    issue(s, a, b, expp, 1'b1);
    chk("busy_launch", {63'b0, bus.busy}, 64'd1);
    chk("mul_reset_launch", {63'b0, mul_reset}, 64'd1);
    wait_idle(n);
    chk("busy_cycles", 64'(n), 64'(LAT + 1));
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a_in = '0; bus.b_in = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_hi", {32'b0, bus.hi}, 64'd0);
    chk("rst_lo", {32'b0, bus.lo}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    chk("rst_mul_reset", {63'b0, mul_reset}, 64'd1);
    chk("rst_mul_a", {32'b0, mul_a}, 64'd0);
    chk("rst_mul_b", {32'b0, mul_b}, 64'd0);
    reset = 1'b0;
    tick();

    bus.mthi = 1'b1; bus.wdata = 32'h1234_5678;
    tick();
    bus.mthi = 1'b0;
    chk("mthi_hi", {32'b0, bus.hi}, 64'h1234_5678);
    chk("mthi_lo_untouched", {32'b0, bus.lo}, 64'd0);

    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_0F0F;
    tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    chk("both_hi", {32'b0, bus.hi}, 64'hA5A5_0F0F);
    chk("both_lo", {32'b0, bus.lo}, 64'hA5A5_0F0F);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b0, 32'hAAAA_AAAA, 32'h8000_0000, 64'h5555_5555_0000_0000);
    run_op(1'b1, 32'hAAAA_AAAA, 32'h8000_0000, 64'h2AAA_AAAB_0000_0000);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Same-cycle start + MTHI: move lands now, product overwrites at capture.
    bus.mthi = 1'b1; bus.wdata = 32'h0BAD_CAFE;
    issue(1'b0, 32'd2, 32'd5, 64'd10, 1'b1);
    bus.mthi = 1'b0;
    chk("start_mthi_hi", {32'b0, bus.hi}, 64'h0BAD_CAFE);
    wait_idle(n);

    // MTLO and a second start during RUN are ignored; operands stay put.
    issue(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    chk("launch_mul_a", {32'b0, mul_a}, 64'd2);
    chk("launch_mul_b", {32'b0, mul_b}, 64'd3);
    repeat (3) tick();
    bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_F00D;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a_in = 32'd7; bus.b_in = 32'd9;
    tick();
    bus.mtlo = 1'b0; bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    chk("run_mtlo_ignored", {32'b0, bus.lo}, 64'd10);
    chk("run_mul_a_stable", {32'b0, mul_a}, 64'd2);
    chk("run_mul_b_stable", {32'b0, mul_b}, 64'd3);
    wait_idle(n);

    // Reset sampled at E10 of a multiply discards it and clears HI/LO.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst_hi", {32'b0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'b0, bus.lo}, 64'd0);
    chk("midrst_mul_reset", {63'b0, mul_reset}, 64'd1);
    chk("midrst_done", {63'b0, bus.done}, 64'd0);
    repeat (40) tick();
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    // Back-to-back: second start presented in the done cycle.
    issue(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b1);
    n = 0;
    while (!bus.done && n < 200) begin
      n++;
      tick();
    end
    chk("b2b_first_done_seen", {63'b0, bus.done}, 64'd1);
    issue(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    chk("b2b_accepted_busy", {63'b0, bus.busy}, 64'd1);
    wait_idle(n);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
